// File: rtl/rice_plane_sequencer.sv
// Rice decoder input-plane sequencer.
// Tracks the undecoded bits held in the 64-bit window, schedules word loads
// and left rotations, and reports each decoded fundamental-sequence value.
//
// state  | meaning
// -------+-----------------------------------------------------------------
// S_IDLE | waiting for a legal start; all command outputs low
// S_FS   | counting leading zeros of the current sample's FS code
// S_REM  | FS value known; waiting for k remainder bits to be in the window
module rice_plane_sequencer #(
    parameter int K_MAX  = 13,
    parameter int FS_MAX = 48
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       start,
    input  logic [3:0] k,
    input  logic [6:0] j,
    input  logic       word_valid,
    output logic       word_ready,
    input  logic [6:0] lz,
    input  logic       lz_found,
    output logic       load,
    output logic [6:0] load_off,
    output logic       shift,
    output logic [6:0] shamt,
    output logic [6:0] bits_avail,
    output logic       sample_valid,
    output logic [5:0] sample_fs,
    output logic       busy,
    output logic       done,
    output logic       err
);

    localparam logic [3:0] K_MAX_L  = 4'(K_MAX);
    localparam logic [7:0] FS_MAX_L = 8'(FS_MAX);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_FS   = 2'd1,
        S_REM  = 2'd2
    } state_t;

    state_t     state;
    logic [3:0] k_r;
    logic [6:0] j_r;
    logic [6:0] count;
    logic [6:0] fs_acc;
    logic [5:0] fs_hold;
    logic [6:0] bits_r;
    logic       err_r;
    logic       busy_r;

    logic       legal_start;
    logic       refill;
    logic [6:0] lz_p1;
    logic [7:0] fs_sum;
    logic [7:0] zero_sum;
    logic       fs_hit;
    logic       fs_flush;
    logic       rem_take;
    logic       fs_bad;
    logic       flush_bad;
    logic       fs_emit;
    logic       last;

    // Per-cycle action decode: refill beats shift, shift beats stall.
    always_comb begin
        legal_start = (k <= K_MAX_L) && (j != 7'd0) && (j <= 7'd64);
        refill      = (state != S_IDLE) && word_valid && (bits_r <= 7'd32);
        lz_p1       = lz + 7'd1;
        fs_sum      = {1'b0, fs_acc} + {1'b0, lz};
        zero_sum    = {1'b0, fs_acc} + {1'b0, bits_r};
        fs_hit      = (state == S_FS) && !refill && lz_found;
        fs_flush    = (state == S_FS) && !refill && !lz_found && (bits_r != 7'd0);
        rem_take    = (state == S_REM) && !refill && (bits_r >= {3'b000, k_r});
        fs_bad      = fs_hit && (fs_sum > FS_MAX_L);
        flush_bad   = fs_flush && (zero_sum > FS_MAX_L);
        fs_emit     = fs_hit && !fs_bad && (k_r == 4'd0);
        last        = ((count + 7'd1) == j_r);
    end

    // Command and status outputs decoded from the current action.
    always_comb begin
        load         = refill;
        word_ready   = refill;
        load_off     = refill ? bits_r : 7'd0;
        shift        = fs_hit || fs_flush || rem_take;
        shamt        = 7'd0;
        if (fs_hit) begin
            shamt = lz_p1;
        end else if (fs_flush) begin
            shamt = bits_r;
        end else if (rem_take) begin
            shamt = {3'b000, k_r};
        end
        sample_valid = fs_emit || rem_take;
        sample_fs    = 6'd0;
        if (fs_emit) begin
            sample_fs = fs_sum[5:0];
        end else if (rem_take) begin
            sample_fs = fs_hold;
        end
        done         = (fs_emit || rem_take) && last;
        bits_avail   = bits_r;
        err          = err_r;
        busy         = busy_r;
    end

    // Sequencer state, window occupancy and per-block bookkeeping.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state   <= S_IDLE;
            k_r     <= 4'd0;
            j_r     <= 7'd0;
            count   <= 7'd0;
            fs_acc  <= 7'd0;
            fs_hold <= 6'd0;
            bits_r  <= 7'd0;
            err_r   <= 1'b0;
            busy_r  <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        if (legal_start) begin
                            k_r    <= k;
                            j_r    <= j;
                            err_r  <= 1'b0;
                            fs_acc <= 7'd0;
                            count  <= 7'd0;
                            bits_r <= 7'd0;
                            busy_r <= 1'b1;
                            state  <= S_FS;
                        end else begin
                            err_r <= 1'b1;
                        end
                    end
                end
                S_FS, S_REM: begin
                    if (refill) begin
                        bits_r <= bits_r + 7'd32;
                    end else if (fs_hit) begin
                        bits_r <= bits_r - lz_p1;
                        if (fs_bad) begin
                            err_r  <= 1'b1;
                            busy_r <= 1'b0;
                            state  <= S_IDLE;
                        end else if (k_r == 4'd0) begin
                            fs_acc <= 7'd0;
                            count  <= count + 7'd1;
                            if (last) begin
                                busy_r <= 1'b0;
                                state  <= S_IDLE;
                            end
                        end else begin
                            fs_hold <= fs_sum[5:0];
                            state   <= S_REM;
                        end
                    end else if (fs_flush) begin
                        // Whole window is zeros: bank them and keep counting.
                        bits_r <= 7'd0;
                        if (flush_bad) begin
                            err_r  <= 1'b1;
                            busy_r <= 1'b0;
                            state  <= S_IDLE;
                        end else begin
                            fs_acc <= zero_sum[6:0];
                        end
                    end else if (rem_take) begin
                        bits_r <= bits_r - {3'b000, k_r};
                        fs_acc <= 7'd0;
                        count  <= count + 7'd1;
                        if (last) begin
                            busy_r <= 1'b0;
                            state  <= S_IDLE;
                        end else begin
                            state <= S_FS;
                        end
                    end
                end
                default: begin
                    busy_r <= 1'b0;
                    state  <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rice_plane_sequencer.sv
// Bench for rice_plane_sequencer: models the bit window as a queue of bits,
// feeds it from generated Rice streams, and scoreboards decoded FS values.
module tb_rice_plane_sequencer;

    localparam int FS_LIMIT = 48;
    localparam int DONE_TOK = 1000;

    logic       clk;
    logic       reset_n;
    logic       start;
    logic [3:0] k;
    logic [6:0] j;
    logic       word_valid;
    logic       word_ready;
    logic [6:0] lz;
    logic       lz_found;
    logic       load;
    logic [6:0] load_off;
    logic       shift;
    logic [6:0] shamt;
    logic [6:0] bits_avail;
    logic       sample_valid;
    logic [5:0] sample_fs;
    logic       busy;
    logic       done;
    logic       err;

    rice_plane_sequencer #(.K_MAX(13), .FS_MAX(48)) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .start       (start),
        .k           (k),
        .j           (j),
        .word_valid  (word_valid),
        .word_ready  (word_ready),
        .lz          (lz),
        .lz_found    (lz_found),
        .load        (load),
        .load_off    (load_off),
        .shift       (shift),
        .shamt       (shamt),
        .bits_avail  (bits_avail),
        .sample_valid(sample_valid),
        .sample_fs   (sample_fs),
        .busy        (busy),
        .done        (done),
        .err         (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          n_checks = 0;
    int          n_errors = 0;
    bit          bitq[$];
    logic [31:0] wq[$];
    logic [31:0] blk_words[$];
    int          exp_q[$];
    int          accepted;
    int          samples_seen;
    int          valid_pct;
    int          exp_err;
    int          exp_consumed;

    task automatic chk(input string name, input int act, input int expv);
        n_checks++;
        if (act != expv) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, expv);
        end
    endtask

    // Window model plus scoreboard monitor: drive lz/word_valid, then observe.
    always @(negedge clk) begin
        int z;
        if (wq.size() > 0 && $urandom_range(0, 99) < valid_pct) word_valid = 1'b1;
        else word_valid = 1'b0;
        z = 0;
        while (z < bitq.size() && bitq[z] == 1'b0) z++;
        lz       = 7'(z);
        lz_found = (z < bitq.size());
        #1;
        if (!reset_n) begin
            bitq.delete();
        end else begin
            if (busy) chk("bits_track", int'(bits_avail), bitq.size());
            if (load) chk("load_off", int'(load_off), bitq.size());
            if (load || shift) chk("one_action", int'(load) + int'(shift), 1);
            if (word_ready) begin
                logic [31:0] w;
                chk("ready_needs_valid", int'(word_valid), 1);
                if (wq.size() > 0) begin
                    w = wq.pop_front();
                    for (int b = 31; b >= 0; b--) bitq.push_back(w[b]);
                    accepted++;
                end
            end
            if (shift) begin
                chk("shamt_fits", int'(int'(shamt) >= 1 && int'(shamt) <= bitq.size()), 1);
                for (int i = 0; i < int'(shamt); i++) if (bitq.size() > 0) void'(bitq.pop_front());
            end
            if (sample_valid) begin
                samples_seen++;
                if (exp_q.size() == 0) chk("sample_unexpected", int'(sample_fs), -1);
                else chk("sample_fs", int'(sample_fs), exp_q.pop_front());
            end
            if (done) begin
                if (exp_q.size() == 0) chk("done_unexpected", 1, 0 + int'(!done));
                else chk("done_token", exp_q.pop_front(), DONE_TOK);
            end
            if (start && !busy && k <= 13 && j >= 1 && j <= 64) bitq.delete();
        end
    end

    // Reference decode of blk_words: FS = zeros before a '1', then k bits.
    task automatic ref_decode(input int kk, input int jj);
        bit          s[$];
        logic [31:0] w;
        int          pos;
        int          z;
        for (int n = 0; n < blk_words.size(); n++) begin
            w = blk_words[n];
            for (int b = 31; b >= 0; b--) s.push_back(w[b]);
        end
        exp_q.delete();
        exp_err = 0;
        pos = 0;
        for (int n = 0; n < jj; n++) begin
            z = 0;
            while (pos < s.size() && s[pos] == 1'b0 && z <= FS_LIMIT) begin
                z++;
                pos++;
            end
            if (z > FS_LIMIT) begin
                exp_err = 1;
                break;
            end
            pos += 1 + kk;
            exp_q.push_back(z);
        end
        if (exp_err == 0) exp_q.push_back(DONE_TOK);
        exp_consumed = pos;
    endtask

    task automatic gen_block(input int kk, input int jj, input bit bad);
        bit          s[$];
        int          err_at;
        int          fs;
        int          r;
        logic [31:0] w;
        err_at = bad ? int'($urandom_range(0, jj - 1)) : -1;
        for (int n = 0; n < jj; n++) begin
            r = $urandom_range(0, 9);
            if (n == err_at) fs = $urandom_range(49, 60);
            else if (r == 0) fs = FS_LIMIT;
            else if (r < 3) fs = $urandom_range(0, FS_LIMIT);
            else fs = $urandom_range(0, 4);
            repeat (fs) s.push_back(1'b0);
            s.push_back(1'b1);
            repeat (kk) s.push_back(1'($urandom_range(0, 1)));
        end
        while (s.size() % 32 != 0) s.push_back(1'($urandom_range(0, 1)));
        blk_words.delete();
        for (int n = 0; n < s.size() / 32; n++) begin
            w = 32'd0;
            for (int b = 0; b < 32; b++) w = {w[30:0], s[32 * n + b]};
            blk_words.push_back(w);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset_n = 1'b0;
        start = 1'b0;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
    endtask

    task automatic run_block(input int kk, input int jj);
        int cyc;
        ref_decode(kk, jj);
        @(negedge clk);
        wq = blk_words;
        accepted = 0;
        samples_seen = 0;
        k = 4'(kk);
        j = 7'(jj);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cyc = 0;
        while (busy && cyc < 6000) begin
            @(negedge clk);
            cyc++;
            // A start while busy must be ignored, even an illegal one.
            if (cyc == 3 && busy) begin
                k = 4'd14;
                start = 1'b1;
            end else begin
                start = 1'b0;
            end
        end
        start = 1'b0;
        chk("busy_drop", int'(busy), 0);
        #2;
        chk("err_end", int'(err), exp_err);
        chk("exp_left", exp_q.size(), 0);
        if (exp_err == 0) chk("bits_end", int'(bits_avail), 32 * accepted - exp_consumed);
        if (busy) do_reset();
    endtask

    task automatic bad_start(input int kk, input int jj);
        @(negedge clk);
        k = 4'(kk);
        j = 7'(jj);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        #2;
        chk("bad_start_err", int'(err), 1);
        chk("bad_start_idle", int'(busy), 0);
    endtask

    initial begin
        int cyc;
        int kk;
        int jj;
        reset_n = 1'b0;
        start = 1'b0;
        k = 4'd0;
        j = 7'd0;
        valid_pct = 100;
        accepted = 0;
        samples_seen = 0;
        repeat (3) @(negedge clk);
        #2;
        chk("reset_outs", int'({busy, err, done, sample_valid, load, shift, word_ready}), 0);
        chk("reset_bits", int'(bits_avail), 0);
        @(negedge clk);
        reset_n = 1'b1;

        // Directed streams.
        blk_words = '{32'h2C000000};
        run_block(2, 2);
        blk_words = '{32'h00000000, 32'h40000000};
        run_block(0, 1);
        blk_words = '{32'h00000000, 32'h00000000, 32'h00000000};
        run_block(0, 1);
        gen_block(13, 3, 1'b0);
        run_block(13, 3);

        bad_start(14, 4);
        bad_start(3, 0);
        bad_start(3, 65);

        // Randomised blocks, including limits of k and j.
        for (int n = 0; n < 30; n++) begin
            valid_pct = $urandom_range(30, 100);
            kk = (n == 0) ? 0 : (n == 1) ? 13 : int'($urandom_range(0, 13));
            jj = (n == 2) ? 64 : (n == 3) ? 1 : int'($urandom_range(1, 20));
            gen_block(kk, jj, $urandom_range(0, 7) == 0);
            run_block(kk, jj);
        end

        // Reset mid-block after the first sample.
        valid_pct = 100;
        gen_block(1, 4, 1'b0);
        ref_decode(1, 4);
        @(negedge clk);
        wq = blk_words;
        samples_seen = 0;
        k = 4'd1;
        j = 7'd4;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cyc = 0;
        while (samples_seen < 1 && cyc < 2000) begin
            @(negedge clk);
            cyc++;
        end
        chk("mid_sample_seen", int'(samples_seen >= 1), 1);
        reset_n = 1'b0;
        #2;
        chk("mid_reset_outs", int'({busy, err, done, sample_valid, load, shift, word_ready}), 0);
        chk("mid_reset_bits", int'(bits_avail), 0);
        @(negedge clk);
        exp_q.delete();
        wq.delete();
        reset_n = 1'b1;
        gen_block(5, 6, 1'b0);
        run_block(5, 6);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/rice_plane_sequencer.md
Name: rice_plane_sequencer

Overview:
- Control block for the Rice decoder's 64-bit input plane (bit window plus left rotator).
- Accepts 32-bit telemetry words over a valid/ready handshake and tracks how many undecoded bits sit in the window.
- Issues load and rotate commands: fundamental-sequence (FS) length, then k remainder bits, for j samples per block.
- Reports each decoded FS value plus block done/error; the datapath supplies a leading-zero count of the current window.

Parameters:
K_MAX, 13, largest legal split value k
FS_MAX, 48, largest legal FS value per sample; above this is a block error

Ports:
clk  in  1  clock, rising edge
reset_n  in  1  asynchronous active-low reset
start  in  1  single-cycle block start; latches k and j
k  in  4  split value, 0..K_MAX
j  in  7  samples per block, 1..64
word_valid  in  1  32-bit input word available
word_ready  out  1  word consumed this cycle (combinational, only when word_valid)
lz  in  7  leading zeros in the top bits_avail bits of the window (from datapath)
lz_found  in  1  a '1' exists within the top bits_avail bits
load  out  1  insert the input word at window offset load_off
load_off  out  7  bit offset from the window MSB for the new word (= bits_avail)
shift  out  1  rotate window left by shamt this cycle
shamt  out  7  rotate amount, 1..64
bits_avail  out  7  undecoded bits in the window, 0..64
sample_valid  out  1  one-cycle pulse: one sample decoded
sample_fs  out  6  FS value of that sample
busy  out  1  block in progress
done  out  1  one-cycle pulse after the j-th sample
err  out  1  sticky error flag, cleared by the next accepted start

Behaviour:
- Reset (async, reset_n low): state IDLE. All outputs 0, including bits_avail, fs_acc, sample count and err. Effective mid-block; no partial sample emitted.
- IDLE:
  - start with k<=K_MAX and 1<=j<=64: latch k and j, clear err, fs_acc, count and bits_avail; go to FS next cycle; busy=1.
  - start with illegal k or j: err=1, remain IDLE.
  - start while busy: ignored.
- One action per cycle in FS or REM. Priority: refill > shift > stall.
- Refill: bits_avail<=32 and word_valid.
  - word_ready=1, load=1, load_off=bits_avail.
  - bits_avail += 32 next cycle; no shift that cycle.
- FS, no refill:
  - lz_found=1: shift=1, shamt=lz+1, bits_avail -= lz+1, fs = fs_acc+lz.
    - fs>FS_MAX: err=1, go to IDLE.
    - k=0: sample_valid=1, sample_fs=fs, fs_acc=0, stay in FS.
    - otherwise: hold fs, go to REM.
  - lz_found=0 and bits_avail>0: shift=1, shamt=bits_avail, fs_acc += bits_avail, bits_avail=0.
    - fs_acc would exceed FS_MAX: err=1, go to IDLE.
  - bits_avail=0 and no word: stall.
- REM, no refill:
  - bits_avail>=k: shift=1, shamt=k, bits_avail -= k, sample_valid=1, sample_fs=fs, fs_acc=0, go to FS.
  - otherwise: stall, waiting for a word.
- Sample count increments on each sample_valid.
  - When it reaches j: done=1 in the same cycle, go to IDLE. busy drops next cycle; bits_avail keeps its value until the next start.
- Outputs load, shift, word_ready, sample_valid and done are combinational decodes of state/inputs and are 0 in IDLE.
- Error exit: busy=0 the next cycle; err holds until the next legal start.
- Width rules: bits_avail never exceeds 64. A refill is only permitted at <=32. shamt=64 only in the all-zero FS case with a full window.

Test Plan:
1. k=2, j=2, start, one word 0x2C000000, then word_valid low -> load(load_off=0, bits 32); shift 3 (bits 29); shift 2 + sample_fs=2; shift 1 (bits 26); shift 2 + sample_fs=0 + done. bits_avail ends at 24.
2. k=0, j=1, words 0x00000000 then 0x40000000 -> load; shift 32 (fs_acc=32, bits 0); load; shift 2 with sample_fs=33 and done in the same cycle.
3. FS_MAX=48, k=0, j=1, three zero words -> first all-zero shift OK (acc=32); second all-zero consume raises err, busy=0. No sample_valid.
4. k=13, window with bits_avail=5 in REM, word_valid low 3 cycles -> no shift, no load; then a word arrives -> load_off=5, bits 37; next cycle shift 13.
5. Refill priority: bits_avail=32 in FS with word_valid=1 and lz_found=1 -> load taken, no shift that cycle; shift follows next cycle.
6. Bad start k=14 -> err=1, stays IDLE. Then reset_n low mid-block (after 1 sample of j=4) -> all outputs 0 immediately; a new legal start works normally.
